audio_capture: RTL and testbench
================================

AUDIO_CAPTURE -- requirements
Module: audio_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 24, meaning codec sample width per channel.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning capture RAM address width.
REQ-003 The block SHALL have parameter DEPTH, default 48000, meaning samples per capture (1 s at 48 kHz); DEPTH <= 2^ADDR_W.
REQ-004 Port: clk  input  1  system clock (CLOCK_50 domain); all logic on rising edge.
REQ-005 Port: reset_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 Port: start  input  1  capture request, level; internally rising-edge detected.
REQ-007 Port: read_ready  input  1  codec ADC FIFO holds a sample pair.
REQ-008 Port: readdata_left  input  DATA_W  codec left sample, two's complement.
REQ-009 Port: readdata_right  input  DATA_W  codec right sample, two's complement.
REQ-010 Port: read  output  1  pop strobe to codec.
REQ-011 Port: mem_wren  output  1  capture RAM write enable.
REQ-012 Port: mem_addr  output  ADDR_W  capture RAM write address.
REQ-013 Port: mem_data  output  DATA_W  capture RAM write data.
REQ-014 Port: busy  output  1  high in CAPTURE.
REQ-015 Port: done  output  1  high in DONE.

Function
REQ-016 FSM states SHALL be IDLE, CAPTURE, DONE; encoding is free.
REQ-017 start_rise SHALL be start=1 while the registered start of the previous cycle is 0.
REQ-018 IDLE -> CAPTURE on start_rise; CAPTURE -> DONE on the cycle the DEPTH-th sample is written; DONE -> CAPTURE on start_rise; no other transitions.
REQ-019 read SHALL equal read_ready in every state (combinational), popping exactly one pair per read_ready cycle; in IDLE and DONE popped pairs are discarded so the FIFO never overflows.
REQ-020 In CAPTURE, a pair SHALL be accepted on each cycle with read=1; mem_data SHALL be (sext(L)+sext(R)) >>> 1 computed at DATA_W+1 bits, arithmetic shift, truncated to DATA_W (no overflow possible).
REQ-021 Latency: mem_wren SHALL pulse for one cycle exactly one cycle after the accepting cycle, with mem_data and mem_addr registered and stable in that cycle.
REQ-022 The write address counter SHALL start at 0 on entry to CAPTURE, increment by 1 after each write, and never exceed DEPTH-1.
REQ-023 mem_addr SHALL hold its last value between writes; it SHALL show DEPTH-1 after the final write until the next capture starts.
REQ-024 Exactly DEPTH writes SHALL occur per capture; a pair popped in the cycle of the final write SHALL be discarded.
REQ-025 A pair accepted on the start_rise cycle itself SHALL be discarded; first accepted pair is on the cycle after entry.
REQ-026 start_rise during CAPTURE SHALL be ignored (no restart, counter unaffected).
REQ-027 start held high SHALL trigger only one capture; a new capture requires start to go low then high.
REQ-028 busy and done SHALL be registered, mutually exclusive, and change on the same edge as the state.

Reset
REQ-029 With reset_n=0 at a clock edge, the state SHALL become IDLE, address counter 0, mem_addr 0, mem_data 0, mem_wren 0, busy 0, done 0, registered start 0.
REQ-030 Reset during CAPTURE SHALL abort immediately; no mem_wren in the cycle after reset is sampled low.
REQ-031 read SHALL still follow read_ready during reset.

Verification
REQ-032 Reset, start pulse, read_ready every 4 cycles with L=0x000010, R=0x000030 -> mem_data 0x000020 at addr 0,1,2..., wren 1 cycle after each read.
REQ-033 L=0x7FFFFF, R=0x7FFFFF -> 0x7FFFFF; L=0x800000, R=0x800000 -> 0x800000; L=0x800000, R=0x7FFFFF -> 0xFFFFFF.
REQ-034 DEPTH=8, read_ready held high -> writes at addr 0..7 on 8 consecutive cycles, done=1 and busy=0 after the addr-7 write, no 9th wren, mem_addr stays 7.
REQ-035 Start held high through two captures' worth of time -> only one capture; toggling start low/high in DONE -> second capture restarts at addr 0.
REQ-036 reset_n low mid-CAPTURE at addr 3 -> IDLE, mem_addr 0, no further wren; start pulse -> capture from addr 0.
REQ-037 IDLE with read_ready high 100 cycles -> read high 100 cycles, mem_wren never asserted.

Source files
------------

// File: rtl/audio_capture.sv
// Captures DEPTH mono samples (average of the codec L/R pair) into a RAM on a start request.
// The codec FIFO is always drained; pairs are only written while capturing.
module audio_capture #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 48000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic              start_q;
  logic              start_rise;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W:0]   sum;

  // Popping never stalls, so the codec FIFO cannot overflow in any state.
  assign read       = read_ready;
  assign start_rise = start & ~start_q;

  // One extra bit keeps the sum exact; the average always fits back in DATA_W.
  assign sum = {readdata_left[DATA_W-1], readdata_left}
             + {readdata_right[DATA_W-1], readdata_right};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      cnt      <= '0;
      mem_wren <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      start_q  <= start;
      mem_wren <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            state <= CAPTURE;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        CAPTURE: begin
          if (read_ready) begin
            mem_wren <= 1'b1;
            mem_addr <= cnt;
            mem_data <= DATA_W'(sum >> 1);
            // Leave on the edge that issues the last write; later pops are dropped.
            if (cnt == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_capture.sv
// Random and directed stimulus for audio_capture, checked every cycle against a
// transaction-level model of the capture sequence.
module tb_audio_capture;
  localparam int DW = 24;
  localparam int AW = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          read_ready = 1'b0;
  logic [DW-1:0] left = '0;
  logic [DW-1:0] right = '0;
  logic          read, mem_wren, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  audio_capture #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .read_ready(read_ready),
    .readdata_left(left), .readdata_right(right), .read(read),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: capture is "active" with n samples written so far; a write
  // appears the cycle after each accepted pair.
  bit          m_cap, m_done, m_pst, m_wren;
  int          m_n;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    s = s >>> 1;
    return s[DW-1:0];
  endfunction

  task automatic model(input logic st, input logic rr, input logic rs,
                       input logic [DW-1:0] dl, input logic [DW-1:0] dr);
    bit rise;
    if (!rs) begin
      m_cap = 0; m_done = 0; m_pst = 0; m_wren = 0; m_n = 0;
      m_addr = '0; m_data = '0;
    end else begin
      rise = st && !m_pst;
      m_pst = st;
      m_wren = 0;
      if (m_cap) begin
        if (rr) begin
          m_wren = 1;
          m_addr = AW'(m_n);
          m_data = avg(dl, dr);
          m_n++;
          if (m_n == DEPTH) begin
            m_cap = 0;
            m_done = 1;
          end
        end
      end else if (rise) begin
        m_cap = 1;
        m_done = 0;
        m_n = 0;
      end
    end
  endtask

  task automatic step(input logic st, input logic rr, input logic rs,
                      input logic [DW-1:0] dl, input logic [DW-1:0] dr);
    @(negedge clk);
    start = st; read_ready = rr; reset_n = rs; left = dl; right = dr;
    #1 chk("read", 32'(read), 32'(rr));
    @(posedge clk);
    model(st, rr, rs, dl, dr);
    #1;
    chk("mem_wren", 32'(mem_wren), 32'(m_wren));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_data", 32'(mem_data), 32'(m_data));
    chk("busy", 32'(busy), 32'(m_cap));
    chk("done", 32'(done), 32'(m_done));
  endtask

  function automatic logic [DW-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return 24'h7FFFFF;
      1: return 24'h800000;
      2: return 24'h000000;
      3: return 24'hFFFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  int wr_cnt;

  initial begin
    // Reset with read_ready wiggling: read must still follow it.
    for (int i = 0; i < 4; i++) step(0, 1'($urandom), 0, rnd(), rnd());

    // Sparse reads of a fixed pair, one capture through to DONE.
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 40; i++)
      step(0, (i % 4) == 3, 1, 24'h000010, 24'h000030);

    // Saturation corners inside a capture.
    step(1, 0, 1, 0, 0);
    step(0, 1, 1, 24'h7FFFFF, 24'h7FFFFF);
    step(0, 1, 1, 24'h800000, 24'h800000);
    step(0, 1, 1, 24'h800000, 24'h7FFFFF);
    for (int i = 0; i < 12; i++) step(0, 1, 1, rnd(), rnd());

    // Back-to-back capture with read_ready stuck high; count the writes.
    wr_cnt = 0;
    step(1, 1, 1, rnd(), rnd());
    for (int i = 0; i < 14; i++) begin
      step(0, 1, 1, rnd(), rnd());
      if (mem_wren) wr_cnt++;
    end
    chk("writes_per_capture", 32'(wr_cnt), 32'(DEPTH));
    chk("final_addr", 32'(mem_addr), 32'(DEPTH - 1));

    // start held high only triggers once; a low/high toggle restarts.
    for (int i = 0; i < 30; i++) step(1, 1, 1, rnd(), rnd());
    step(0, 1, 1, rnd(), rnd());
    step(0, 1, 1, rnd(), rnd());
    for (int i = 0; i < 15; i++) step(1, 1, 1, rnd(), rnd());

    // Abort mid-capture, then capture again from address 0.
    step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, rnd(), rnd());
    step(1, 1, 0, rnd(), rnd());
    for (int i = 0; i < 3; i++) step(0, 1, 1, rnd(), rnd());
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1, rnd(), rnd());

    // Idle draining: read follows read_ready, no writes.
    step(0, 0, 0, 0, 0);
    wr_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 1, rnd(), rnd());
      if (mem_wren) wr_cnt++;
    end
    chk("idle_writes", 32'(wr_cnt), 32'd0);

    // Random soak.
    begin
      logic st = 0;
      for (int i = 0; i < 2500; i++) begin
        if ($urandom_range(0, 9) == 0) st = ~st;
        step(st, 1'($urandom), ($urandom_range(0, 199) != 0), rnd(), rnd());
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
